// File: rtl/timing_gen_if.sv
// Divisor configuration port of timing_gen.
// The master issues single-cycle writes. The slave answers each write with a
// one-cycle acknowledge, and a reject flag that is valid alongside it.
interface timing_gen_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 27
) ();

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ack,
    output cfg_err
  );

endinterface

// File: rtl/timing_gen.sv
// Multi-channel timing generator.
// Each channel divides clk_sys by a runtime-programmable divisor D and produces
// two outputs: a one-cycle tick every D cycles, and a 50% clock that toggles on
// every tick.
// A divisor written while a channel runs is held as pending. It is installed
// only at that channel's terminal count, so the running period always
// completes with the old divisor and clk_out never shows a short pulse.
module timing_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 500_000
) (
  input  logic              clk_sys,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  timing_gen_if.slave       cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // A write is refused for a zero divisor or for a channel that does not exist.
  function automatic logic cfg_reject(input logic [CH_W-1:0] ch,
                                      input logic [CNT_W-1:0] div);
    logic bad_div;
    logic bad_ch;
    bad_div    = (div == {CNT_W{1'b0}});
    bad_ch     = (32'(ch) >= 32'(NUM_CH));
    cfg_reject = bad_div | bad_ch;
  endfunction

  logic [CNT_W-1:0]  cnt_r      [NUM_CH];
  logic [CNT_W-1:0]  div_r      [NUM_CH];
  logic [CNT_W-1:0]  pend_div_r [NUM_CH];
  logic [NUM_CH-1:0] pend_vld_r;
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] clk_out_r;
  logic              cfg_ack_r;
  logic              cfg_err_r;

  logic              wr_bad_s;
  logic [NUM_CH-1:0] wr_sel_s;
  logic [NUM_CH-1:0] term_s;

  // Decode the write target and flag channels at their terminal count.
  always_comb begin
    wr_bad_s = cfg_reject(cfg.cfg_ch, cfg.cfg_div);
    wr_sel_s = {NUM_CH{1'b0}};
    term_s   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      term_s[i] = (cnt_r[i] == (div_r[i] - ONE));
      if (cfg.cfg_we && !wr_bad_s && (cfg.cfg_ch == CH_W'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  // Acknowledge every write one cycle later, and flag it if it was refused.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      cfg_ack_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_ack_r <= cfg.cfg_we;
      cfg_err_r <= cfg.cfg_we & wr_bad_s;
    end
  end

  // Per-channel counter, divisor install and registered tick/clk_out.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]      <= {CNT_W{1'b0}};
        div_r[i]      <= DIV_RST;
        pend_div_r[i] <= DIV_RST;
      end
      pend_vld_r <= {NUM_CH{1'b0}};
      tick_r     <= {NUM_CH{1'b0}};
      clk_out_r  <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_clr) begin
          // Phase-align all channels. Counters return to zero here, so a
          // fresh write or a pending divisor can be installed immediately.
          cnt_r[i]      <= {CNT_W{1'b0}};
          tick_r[i]     <= 1'b0;
          clk_out_r[i]  <= 1'b0;
          pend_vld_r[i] <= 1'b0;
          if (wr_sel_s[i]) begin
            div_r[i] <= cfg.cfg_div;
          end else if (pend_vld_r[i]) begin
            div_r[i] <= pend_div_r[i];
          end else begin
            div_r[i] <= div_r[i];
          end
        end else if (ch_en[i]) begin
          if (term_s[i]) begin
            // End of period. Wrap the counter and install any divisor that
            // was pending before this edge. A write arriving on this same
            // edge waits for the following terminal count.
            cnt_r[i]     <= {CNT_W{1'b0}};
            tick_r[i]    <= 1'b1;
            clk_out_r[i] <= ~clk_out_r[i];
            if (pend_vld_r[i]) begin
              div_r[i] <= pend_div_r[i];
            end else begin
              div_r[i] <= div_r[i];
            end
            if (wr_sel_s[i]) begin
              pend_div_r[i] <= cfg.cfg_div;
              pend_vld_r[i] <= 1'b1;
            end else begin
              pend_vld_r[i] <= 1'b0;
            end
          end else begin
            // Mid-period. A write is only parked as pending; the last
            // write wins.
            cnt_r[i]  <= cnt_r[i] + ONE;
            tick_r[i] <= 1'b0;
            if (wr_sel_s[i]) begin
              pend_div_r[i] <= cfg.cfg_div;
              pend_vld_r[i] <= 1'b1;
            end else begin
              pend_vld_r[i] <= pend_vld_r[i];
            end
          end
        end else begin
          // A disabled channel holds its phase. A write here lands directly
          // in the divisor and restarts the count, and it replaces anything
          // that was still pending.
          tick_r[i] <= 1'b0;
          if (wr_sel_s[i]) begin
            div_r[i]      <= cfg.cfg_div;
            cnt_r[i]      <= {CNT_W{1'b0}};
            pend_vld_r[i] <= 1'b0;
          end else begin
            cnt_r[i] <= cnt_r[i];
          end
        end
      end
    end
  end

  assign tick        = tick_r;
  assign clk_out     = clk_out_r;
  assign cfg.cfg_ack = cfg_ack_r;
  assign cfg.cfg_err = cfg_err_r;

endmodule
